// File: rtl/square_accum.sv
// square_accum: reconstructs a radicand from a square-root result, d = q*q + r,
// with a 16-step shift-and-add multiplier that accumulates onto a remainder preload.
//
// Ports:
//   clock  - sole clock, all state updates on the rising edge
//   reset  - synchronous, active-high; overrides load and any operation in flight
//   load   - start pulse; captures q and r, restarts even when busy
//   q      - 16-bit root operand
//   r      - 17-bit remainder operand
//   d      - low 32 bits of the accumulator (q*q + r once finished)
//   ovf    - bit 32 of the accumulator
//   valid  - r <= 2*q for the captured operands; changes only on load or reset
//   busy   - operation in progress
//   ready  - one-cycle pulse on the cycle after the last execution edge
//   count  - iteration counter, 0..15 during an operation
module square_accum (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] q,
    input  logic [16:0] r,
    output logic [31:0] d,
    output logic        ovf,
    output logic        valid,
    output logic        busy,
    output logic        ready,
    output logic [3:0]  count
);

    logic [15:0] mplier_q, mplier_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [32:0] acc_q,    acc_d;
    logic [3:0]  count_q,  count_d;
    logic        busy_q,   busy_d;
    logic        busy_dly_q, busy_dly_d;
    logic        valid_q,  valid_d;

    always_comb begin
        mplier_d   = mplier_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        count_d    = count_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        busy_dly_d = busy_q;

        if (load) begin
            // Preloading the accumulator with r folds the "+ r" into the multiply.
            mplier_d = q;
            mcand_d  = {16'b0, q};
            acc_d    = {16'b0, r};
            count_d  = 4'd0;
            busy_d   = 1'b1;
            valid_d  = (r <= {q, 1'b0});
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + {1'b0, mcand_q};
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            count_d  = count_q + 4'd1;
            // Sixteenth execution edge: count wraps to 0 on its own.
            if (count_q == 4'hf) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mplier_q   <= 16'd0;
            mcand_q    <= 32'd0;
            acc_q      <= 33'd0;
            count_q    <= 4'd0;
            busy_q     <= 1'b0;
            busy_dly_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            mplier_q   <= mplier_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            busy_dly_q <= busy_dly_d;
            valid_q    <= valid_d;
        end
    end

    // A load during an operation keeps busy high, so an aborted op never pulses ready.
    assign ready = ~busy_q & busy_dly_q;
    assign d     = acc_q[31:0];
    assign ovf   = acc_q[32];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: tb/tb_square_accum.sv
module tb_square_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] q;
    logic [16:0] r;
    logic [31:0] d;
    logic        ovf;
    logic        valid;
    logic        busy;
    logic        ready;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    square_accum dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .q     (q),
        .r     (r),
        .d     (d),
        .ovf   (ovf),
        .valid (valid),
        .busy  (busy),
        .ready (ready),
        .count (count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the radicand is simply q*q + r, and valid is r <= 2q.
    function automatic logic [32:0] model_sum(input logic [15:0] qq, input logic [16:0] rr);
        longint s;
        s = longint'(qq) * longint'(qq) + longint'(rr);
        return s[32:0];
    endfunction

    function automatic logic model_valid(input logic [15:0] qq, input logic [16:0] rr);
        return longint'(rr) <= 2 * longint'(qq);
    endfunction

    // Entered just after a falling edge. Issues one load and follows the
    // operation through its 16 execution edges. With chain set, returns on the
    // ready cycle so the caller can load again in that same cycle.
    task automatic run_op(input logic [15:0] qq, input logic [16:0] rr, input bit chain);
        logic [32:0] exp_sum;
        logic        exp_valid;
        exp_sum   = model_sum(qq, rr);
        exp_valid = model_valid(qq, rr);
        load = 1'b1;
        q    = qq;
        r    = rr;
        @(negedge clock);
        load = 1'b0;
        q    = 16'($urandom);
        r    = 17'($urandom);
        check_eq("busy_after_load", 64'(busy), 64'd1);
        check_eq("count_after_load", 64'(count), 64'd0);
        check_eq("valid_after_load", 64'(valid), 64'(exp_valid));
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k < 16) begin
                check_eq("ready_early", 64'(ready), 64'd0);
                check_eq("count_step", 64'(count), 64'(k));
                check_eq("valid_stable", 64'(valid), 64'(exp_valid));
            end else begin
                check_eq("ready_pulse", 64'(ready), 64'd1);
                check_eq("busy_done", 64'(busy), 64'd0);
                check_eq("count_wrap", 64'(count), 64'd0);
                check_eq("d_result", 64'(d), 64'(exp_sum[31:0]));
                check_eq("ovf_result", 64'(ovf), 64'(exp_sum[32]));
                check_eq("valid_result", 64'(valid), 64'(exp_valid));
            end
        end
        if (!chain) begin
            @(negedge clock);
            check_eq("ready_single", 64'(ready), 64'd0);
            check_eq("d_hold", 64'(d), 64'(exp_sum[31:0]));
            check_eq("ovf_hold", 64'(ovf), 64'(exp_sum[32]));
            check_eq("valid_hold", 64'(valid), 64'(exp_valid));
        end
    endtask

    initial begin
        logic [15:0] rq;
        logic [16:0] rr;

        reset = 1'b1;
        load  = 1'b0;
        q     = 16'd0;
        r     = 17'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_d", 64'(d), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        repeat (3) @(negedge clock);
        check_eq("idle_d", 64'(d), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Directed corner operands.
        run_op(16'h0003, 17'h00005, 1'b0);
        run_op(16'hFFFF, 17'h1FFFE, 1'b0);
        run_op(16'h0000, 17'h00000, 1'b0);
        run_op(16'h0002, 17'h00005, 1'b0);
        run_op(16'hFFFF, 17'h1FFFF, 1'b0);

        // Restart at count 7: the first op must never pulse ready.
        load = 1'b1;
        q    = 16'h1234;
        r    = 17'h00000;
        @(negedge clock);
        load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check_eq("abort_no_ready", 64'(ready), 64'd0);
        end
        check_eq("abort_count7", 64'(count), 64'd7);
        run_op(16'h0010, 17'h00003, 1'b0);

        // Reset at count 9.
        load = 1'b1;
        q    = 16'h1234;
        r    = 17'h00000;
        @(negedge clock);
        load = 1'b0;
        repeat (9) @(negedge clock);
        check_eq("pre_rst_count9", 64'(count), 64'd9);
        check_eq("pre_rst_valid", 64'(valid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_count", 64'(count), 64'd0);
        check_eq("mid_rst_d", 64'(d), 64'd0);
        check_eq("mid_rst_valid", 64'(valid), 64'd0);
        check_eq("mid_rst_ovf", 64'(ovf), 64'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check_eq("post_rst_ready", 64'(ready), 64'd0);
            check_eq("post_rst_d", 64'(d), 64'd0);
        end

        // Back-to-back: second load lands in the ready cycle.
        run_op(16'h00AB, 17'h00011, 1'b1);
        check_eq("b2b_ready_with_load", 64'(ready), 64'd1);
        run_op(16'h4321, 17'h00123, 1'b0);

        // Random operands, biased toward consistent remainders.
        for (int i = 0; i < 40; i++) begin
            rq = 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                rr = 17'($urandom_range(0, 2 * int'(rq)));
            end else begin
                rr = 17'($urandom);
            end
            run_op(rq, rr, (i % 5) == 4);
        end
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/square_accum.md
SQUARE_ACCUM -- requirements
Module: square_accum

Interface
REQ-001 SHALL have no parameters; widths fixed at 16-bit root, 17-bit remainder, 32-bit radicand.
REQ-002 SHALL provide: clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide: load  input  1  start pulse (ID stage: load = is_sqr & ~busy), sampled each edge.
REQ-005 SHALL provide: q  input  16  root operand, captured on load.
REQ-006 SHALL provide: r  input  17  remainder operand, captured on load.
REQ-007 SHALL provide: d  output  32  reconstructed radicand, d = q*q + r (low 32 bits).
REQ-008 SHALL provide: ovf  output  1  bit 32 of q*q + r.
REQ-009 SHALL provide: valid  output  1  remainder consistent with root, i.e. r <= 2*q.
REQ-010 SHALL provide: busy  output  1  operation in progress; new load not accepted by CPU.
REQ-011 SHALL provide: ready  output  1  one-cycle pulse, result available.
REQ-012 SHALL provide: count  output  4  iteration counter, simulation visibility.

Function
REQ-013 On load: capture multiplier reg = q, multiplicand reg = {16'b0,q}, 33-bit accumulator = {16'b0,r}; count = 0; busy = 1; valid = (r <= {q,1'b0}) using 17-bit unsigned compare.
REQ-014 Each edge with busy=1 and load=0: if multiplier bit0 = 1, accumulator += multiplicand (33-bit add, zero-extended); multiplier shifts right 1; multiplicand shifts left 1 (32-bit); count increments.
REQ-015 Exactly 16 execution edges per operation; on the edge where count == 4'hf, busy clears and count wraps to 0.
REQ-016 Latency: load sampled at edge E0, execution at E1..E16; after E16 d/ovf final and ready = 1 for exactly the cycle between E16 and E17.
REQ-017 ready SHALL be ~busy & busy_d, busy_d being busy delayed one edge; never high two consecutive cycles.
REQ-018 d = accumulator[31:0], ovf = accumulator[32]; both combinational from registers, intermediate values visible while busy, stable from E16 until next load or reset.
REQ-019 valid SHALL change only on load or reset; stable throughout and after the operation.
REQ-020 load while busy: load wins; operands recaptured, count = 0, operation restarts; no ready pulse for aborted operation.
REQ-021 load in the same cycle as ready: new operation starts; ready still pulses that cycle; busy=1 after edge.
REQ-022 load with busy=0 and no prior op: normal start; idle with no load: all registers hold.
REQ-023 For any r <= 2*q, ovf SHALL be 0 (max (q+1)^2-1 <= 2^32-1); ovf = 1 only when valid = 0.

Reset
REQ-024 reset=1 at an edge SHALL set busy=0, busy_d=0, count=0, accumulator=0, multiplier/multiplicand=0, valid=0; hence d=0, ovf=0, ready=0.
REQ-025 reset has priority over load and over an in-progress operation; aborted operation produces no ready pulse.
REQ-026 Outputs SHALL hold reset values until first load after reset deasserts.

Verification
REQ-027 q=0x0003, r=0x00005 load -> after 16 cycles ready pulse, d=0x0000000E, ovf=0, valid=1.
REQ-028 q=0xFFFF, r=0x1FFFE -> d=0xFFFFFFFF, ovf=0, valid=1; q=0x0000, r=0x00000 -> d=0, valid=1.
REQ-029 q=0x0002, r=0x00005 -> d=0x00000009, valid=0; q=0xFFFF, r=0x1FFFF -> d=0x00000000, ovf=1, valid=0.
REQ-030 Start q=0x1234,r=0; assert load at count=7 with q=0x0010,r=0x00003 -> single ready 16 cycles after second load, d=0x00000103, count progression restarts at 0.
REQ-031 Assert reset at count=9 -> next cycle busy=0, count=0, d=0, valid=0; no ready pulse in following 20 cycles without load.
REQ-032 Back-to-back: load asserted in ready cycle -> ready pulses, busy stays 1, second result correct 16 cycles later.
